// File: rtl/dmem_resp_if.sv
// Load/store bundle between the SISC control unit (master) and the data-memory
// responder (slave). Clock and reset travel as plain ports alongside it.
interface dmem_resp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, err, rdata
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store, holds it for WAIT cycles, then
// commits the write or returns the read word alongside a one-cycle ack.
module dmem_resp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WAIT   = 2
) (
  input logic        clk,
  input logic        rst,
  dmem_resp_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Full-width compare so that aliased high addresses are never treated as in range.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  state_e            state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              busy_r;
  logic              ack_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              commit_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;

  // Decode of the completing edge and the array index of the captured address.
  always_comb begin
    in_range_s = addr_in_range(addr_r);
    idx_s      = addr_r[IDX_W-1:0];
    if ((state_r == ST_WAIT) && (cnt_r == 4'd0)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Control FSM with request capture and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req) begin
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            cnt_r   <= WAIT[3:0];
            busy_r  <= 1'b1;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (commit_s) begin
            state_r <= ST_RESP;
            ack_r   <= 1'b1;
            err_r   <= ~in_range_s;
            if (!we_r) begin
              rdata_r <= in_range_s ? mem_r[idx_s] : {DATA_W{1'b0}};
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && we_r && in_range_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  assign bus.busy  = busy_r;
  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (WAIT=2, 0, 15) checked against a
// transaction-level model of memory contents, latency and error flags.
module tb_dmem_resp;

  logic clk;
  logic rst;

  logic        req_a   [3];
  logic        we_a    [3];
  logic [15:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic        busy_a  [3];
  logic        ack_a   [3];
  logic        err_a   [3];
  logic [31:0] rdata_a [3];

  int waits [3] = '{2, 0, 15};

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata [3];

  dmem_resp_if #(.DATA_W(32), .ADDR_W(16)) bus_w2 ();
  dmem_resp_if #(.DATA_W(32), .ADDR_W(16)) bus_w0 ();
  dmem_resp_if #(.DATA_W(32), .ADDR_W(16)) bus_w15 ();

  dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT(2))  u_dut_w2  (.clk(clk), .rst(rst), .bus(bus_w2));
  dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT(0))  u_dut_w0  (.clk(clk), .rst(rst), .bus(bus_w0));
  dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT(15)) u_dut_w15 (.clk(clk), .rst(rst), .bus(bus_w15));

  assign bus_w2.req   = req_a[0];
  assign bus_w2.we    = we_a[0];
  assign bus_w2.addr  = addr_a[0];
  assign bus_w2.wdata = wdata_a[0];
  assign busy_a[0]    = bus_w2.busy;
  assign ack_a[0]     = bus_w2.ack;
  assign err_a[0]     = bus_w2.err;
  assign rdata_a[0]   = bus_w2.rdata;

  assign bus_w0.req   = req_a[1];
  assign bus_w0.we    = we_a[1];
  assign bus_w0.addr  = addr_a[1];
  assign bus_w0.wdata = wdata_a[1];
  assign busy_a[1]    = bus_w0.busy;
  assign ack_a[1]     = bus_w0.ack;
  assign err_a[1]     = bus_w0.err;
  assign rdata_a[1]   = bus_w0.rdata;

  assign bus_w15.req   = req_a[2];
  assign bus_w15.we    = we_a[2];
  assign bus_w15.addr  = addr_a[2];
  assign bus_w15.wdata = wdata_a[2];
  assign busy_a[2]     = bus_w15.busy;
  assign ack_a[2]      = bus_w15.ack;
  assign err_a[2]      = bus_w15.err;
  assign rdata_a[2]    = bus_w15.rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int u, input logic [15:0] a);
    return u * 65536 + int'(a);
  endfunction

  // Expected outcome of one completed request, from the responder's rules.
  task automatic model_complete(input int u, input logic w, input logic [15:0] a,
                                input logic [31:0] d, output logic exp_err);
    exp_err = (a >= 16'd256);
    if (w) begin
      if (!exp_err) ref_mem[key(u, a)] = d;
    end else begin
      ref_rdata[u] = exp_err ? 32'h0 : ref_mem[key(u, a)];
    end
  endtask

  // One request on instance u, starting at a negedge with the DUT idle.
  task automatic txn(input int u, input logic w, input logic [15:0] a,
                     input logic [31:0] d, output time t_ack);
    int   k;
    logic exp_err;
    req_a[u] = 1'b1; we_a[u] = w; addr_a[u] = a; wdata_a[u] = d;
    @(negedge clk);
    req_a[u] = 1'b0; we_a[u] = 1'($urandom); addr_a[u] = 16'($urandom); wdata_a[u] = $urandom;
    check("busy_after_accept", 32'(busy_a[u]), 32'h1);
    k = 0;
    while (ack_a[u] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    t_ack = $time;
    check("ack_latency", 32'(k), 32'(waits[u] + 1));
    model_complete(u, w, a, d, exp_err);
    check("err_with_ack", 32'(err_a[u]), 32'(exp_err));
    check("rdata_with_ack", rdata_a[u], ref_rdata[u]);
    check("busy_in_resp", 32'(busy_a[u]), 32'h1);
    @(negedge clk);
    check("ack_one_cycle", 32'(ack_a[u]), 32'h0);
    check("err_clears", 32'(err_a[u]), 32'h0);
    check("idle_after_resp", 32'(busy_a[u]), 32'h0);
  endtask

  initial begin
    time t_ack;
    time t_prev;
    int  k;
    int  extra_acks;
    logic exp_err;

    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      req_a[u] = 1'b0; we_a[u] = 1'b0; addr_a[u] = 16'h0; wdata_a[u] = 32'h0;
      ref_rdata[u] = 32'h0;
    end

    // Reset held for three cycles, then released.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("reset_busy", 32'(busy_a[u]), 32'h0);
      check("reset_ack", 32'(ack_a[u]), 32'h0);
      check("reset_err", 32'(err_a[u]), 32'h0);
      check("reset_rdata", rdata_a[u], 32'h0);
    end

    // Write/read round trip.
    txn(0, 1'b1, 16'd5, 32'hDEADBEEF, t_ack);
    txn(0, 1'b0, 16'd5, 32'h0, t_ack);
    check("roundtrip_rdata", rdata_a[0], 32'hDEADBEEF);

    // Out of range: aliased write must not land on word 5.
    txn(0, 1'b1, 16'h0105, 32'h00001234, t_ack);
    txn(0, 1'b0, 16'h0005, 32'h0, t_ack);
    txn(0, 1'b0, 16'h0105, 32'h0, t_ack);
    txn(0, 1'b1, 16'h00FF, 32'hCAFEF00D, t_ack);
    txn(0, 1'b0, 16'h0100, 32'h0, t_ack);
    txn(0, 1'b0, 16'h00FF, 32'h0, t_ack);
    txn(0, 1'b0, 16'hFFFF, 32'h0, t_ack);

    // Request pulsed during WAIT of a read must be ignored.
    txn(0, 1'b1, 16'd3, 32'h33333333, t_ack);
    txn(0, 1'b1, 16'd7, 32'h77777777, t_ack);
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 16'd3; wdata_a[0] = 32'h0;
    @(negedge clk);
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 16'd7; wdata_a[0] = 32'h00000BAD;
    @(negedge clk);
    req_a[0] = 1'b0;
    k = 0;
    while (ack_a[0] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    model_complete(0, 1'b0, 16'd3, 32'h0, exp_err);
    check("ignore_ack_seen", 32'(ack_a[0]), 32'h1);
    check("ignore_rdata", rdata_a[0], ref_rdata[0]);
    extra_acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack_a[0] === 1'b1) extra_acks++;
    end
    check("ignore_no_second_ack", 32'(extra_acks), 32'h0);
    txn(0, 1'b0, 16'd7, 32'h0, t_ack);

    // Reset during WAIT of a write aborts it without ack.
    txn(0, 1'b1, 16'd9, 32'h11111111, t_ack);
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 16'd9; wdata_a[0] = 32'hAAAA5555;
    @(negedge clk);
    req_a[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy_a[0]), 32'h0);
    check("abort_ack", 32'(ack_a[0]), 32'h0);
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 16'd9;
    @(negedge clk);
    check("no_accept_in_reset", 32'(busy_a[0]), 32'h0);
    check("abort_ack_late", 32'(ack_a[0]), 32'h0);
    for (int u = 0; u < 3; u++) ref_rdata[u] = 32'h0;
    check("reset_clears_rdata", rdata_a[0], 32'h0);
    rst = 1'b0;
    txn(0, 1'b0, 16'd9, 32'h0, t_ack);
    check("abort_kept_old", rdata_a[0], 32'h11111111);

    // Latency sweep: back-to-back reads at WAIT=0 and WAIT=15.
    for (int u = 1; u < 3; u++) begin
      txn(u, 1'b1, 16'd1, 32'h0000_0100 + 32'(u), t_ack);
      txn(u, 1'b1, 16'd2, 32'h0000_0200 + 32'(u), t_ack);
      txn(u, 1'b0, 16'd1, 32'h0, t_prev);
      for (int i = 0; i < 3; i++) begin
        txn(u, 1'b0, (i % 2 == 0) ? 16'd2 : 16'd1, 32'h0, t_ack);
        check("ack_interval", 32'(t_ack - t_prev), 32'((waits[u] + 3) * 10));
        t_prev = t_ack;
      end
    end

    // Randomized mix of reads and writes on the WAIT=2 instance.
    for (int i = 0; i < 40; i++) begin
      int          r;
      logic        w;
      logic [15:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = 16'($urandom_range(0, 15));
      else if (r < 9) a = 16'($urandom_range(256, 300));
      else            a = 16'hFFFF;
      w = 1'($urandom_range(0, 1));
      if (!w && (a < 16'd256) && !ref_mem.exists(key(0, a))) w = 1'b1;
      txn(0, w, a, $urandom, t_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
